// File: rtl/piano_pkg.sv
// Shared tone constants for the buzzer driver and the note detector.
// Both ends index notes 1..7 (do..si); 0 means no note.
package piano_pkg;

  localparam int NOTE_NONE = 0;

  // Nominal half-periods in clk cycles at 100 MHz, index 7 leftmost.
  localparam logic [7:1][31:0] NOTE_HP = {
    32'd202430, 32'd227274, 32'd255103, 32'd285715,
    32'd303031, 32'd340137, 32'd381681
  };

  typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} nd_state_e;

  // Returns the note whose +/-tol window contains hp, else NOTE_NONE.
  function automatic logic [3:0] classify(input logic [31:0] hp,
                                          input logic [7:1][31:0] nom,
                                          input logic [31:0] tol);
    classify = 4'(NOTE_NONE);
    for (int k = 1; k <= 7; k++)
      if (hp >= nom[k] - tol && hp <= nom[k] + tol) classify = 4'(k);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a one-cycle strobe on either edge of the
// synchronized signal.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_stb
);

  // sh[1] is the synchronized level, sh[2] its previous value
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], din};

  assign edge_stb = sh[2] ^ sh[1];

endmodule

// File: rtl/note_detector.sv
// Measures the half-period of a tone square wave and reports the matching
// note once LOCK_CNT consecutive half-periods agree.
module note_detector
  import piano_pkg::*;
#(
  parameter int               CNT_W    = 20,
  parameter int               TOL      = 1024,
  parameter int               LOCK_CNT = 2,
  parameter int               TIMEOUT  = 500000,
  parameter logic [7:1][31:0] NOM      = NOTE_HP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tone_in,
  output logic [3:0] note,
  output logic       note_valid,
  output logic       note_change
);

  localparam int              MW  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LCK = MW'(LOCK_CNT);

  nd_state_e        state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand, cand_n, note_n, cls;
  logic [MW-1:0]    mcnt, mcnt_n;
  logic             edge_stb, tmo_hit;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (tone_in),
    .edge_stb (edge_stb)
  );

  // cnt equals the strobe-to-strobe distance in the strobe cycle
  always_ff @(posedge clk or posedge rst)
    if (rst)             cnt <= '0;
    else if (!enable)    cnt <= '0;
    else if (edge_stb)   cnt <= CNT_W'(1);
    else if (cnt < TMO)  cnt <= cnt + 1'b1;

  assign cls     = classify(32'(cnt), NOM, 32'(TOL));
  assign tmo_hit = (cnt == TMO);

  always_comb begin
    state_n = state;
    cand_n  = cand;
    mcnt_n  = mcnt;
    note_n  = note;
    unique case (state)
      SILENT:
        if (edge_stb) begin
          state_n = ACQUIRE;
          cand_n  = 4'(NOTE_NONE);
          mcnt_n  = '0;
        end
      ACQUIRE:
        if (edge_stb) begin
          if (cls != 4'(NOTE_NONE) && cls == cand) begin
            mcnt_n = mcnt + 1'b1;
          end else begin
            cand_n = cls;
            mcnt_n = MW'(cls != 4'(NOTE_NONE));
          end
          if (cls != 4'(NOTE_NONE) && mcnt_n >= LCK) begin
            state_n = LOCKED;
            note_n  = cls;
          end
        end else if (tmo_hit) begin
          state_n = SILENT;
          cand_n  = 4'(NOTE_NONE);
          mcnt_n  = '0;
        end
      LOCKED:
        if (edge_stb) begin
          if (cls != note) begin
            state_n = ACQUIRE;
            cand_n  = cls;
            mcnt_n  = MW'(cls != 4'(NOTE_NONE));
            note_n  = 4'(NOTE_NONE);
          end
        end else if (tmo_hit) begin
          state_n = SILENT;
          cand_n  = 4'(NOTE_NONE);
          mcnt_n  = '0;
          note_n  = 4'(NOTE_NONE);
        end
      default: state_n = SILENT;
    endcase
    if (!enable) begin
      state_n = SILENT;
      cand_n  = 4'(NOTE_NONE);
      mcnt_n  = '0;
      note_n  = 4'(NOTE_NONE);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= SILENT;
      cand        <= 4'(NOTE_NONE);
      mcnt        <= '0;
      note        <= 4'(NOTE_NONE);
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      mcnt        <= mcnt_n;
      note        <= note_n;
      note_valid  <= (state_n == LOCKED);
      // back-to-back changes are folded so the pulse never stretches
      note_change <= (note_n != note) && !note_change;
    end

endmodule

// File: tb/tb_note_detector.sv
// Scoreboarded bench: the tone generator predicts every note_change event
// from a toggle-level model; a monitor pops and compares on each pulse.
module tb_note_detector;

  localparam int TOL  = 8;
  localparam int LOCK = 2;
  localparam int TMO  = 3000;

  // Half-periods scaled by 1/200 so a full run stays short.
  int nomt [1:7] = '{1908, 1701, 1515, 1429, 1275, 1136, 1012};

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b1, tone_in = 1'b0;
  logic [3:0] note;
  logic       note_valid, note_change;

  note_detector #(
    .CNT_W(12), .TOL(TOL), .LOCK_CNT(LOCK), .TIMEOUT(TMO),
    .NOM({32'd1012, 32'd1136, 32'd1275, 32'd1429, 32'd1515, 32'd1701, 32'd1908})
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .tone_in(tone_in),
    .note(note), .note_valid(note_valid), .note_change(note_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int note; bit valid; } ev_t;
  ev_t q[$];
  int  checks = 0, errors = 0;

  // model: 0 silent, 1 listening, 2 locked
  int m_st = 0, m_cand = 0, m_cnt = 0, m_note = 0, m_last = 0;

  function automatic int cls(int hp);
    for (int k = 1; k <= 7; k++)
      if (hp >= nomt[k] - TOL && hp <= nomt[k] + TOL) return k;
    return 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_change(int at, int nn);
    ev_t e;
    e.cyc = at; e.note = nn; e.valid = (nn != 0);
    q.push_back(e);
  endtask

  task automatic m_silence();
    m_st = 0; m_note = 0; m_cand = 0; m_cnt = 0;
  endtask

  // Output of a strobe appears 3 edges after the toggle; a silent gap is
  // declared TMO cycles after that.
  task automatic m_timeout_chk(int now);
    if (m_st != 0 && now - m_last > TMO) begin
      if (m_note != 0) expect_change(m_last + 3 + TMO, 0);
      m_silence();
    end
  endtask

  task automatic m_edge(int now);
    int hp, c;
    m_timeout_chk(now);
    hp = (now - m_last > TMO) ? TMO : now - m_last;
    c  = cls(hp);
    if (m_st == 0) begin
      m_st = 1; m_cand = 0; m_cnt = 0;
    end else if (m_st == 2) begin
      if (c != m_note) begin
        m_st = 1; m_cand = c; m_cnt = (c != 0) ? 1 : 0; m_note = 0;
        expect_change(now + 3, 0);
      end
    end else begin
      if (c != 0 && c == m_cand) m_cnt++;
      else begin m_cand = c; m_cnt = (c != 0) ? 1 : 0; end
      if (c != 0 && m_cnt >= LOCK) begin
        m_st = 2; m_note = c;
        expect_change(now + 3, c);
      end
    end
    m_last = now;
  endtask

  // Wait d cycles (d >= 5), checking the steady outputs on the way, then toggle.
  task automatic tog(int d);
    repeat (5) @(negedge clk);
    chk("note_level", int'(note), m_note);
    chk("valid_level", int'(note_valid), (m_st == 2) ? 1 : 0);
    m_timeout_chk(cyc + d - 5);
    repeat (d - 5) @(negedge clk);
    tone_in = ~tone_in;
    m_edge(cyc);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (note_change) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse: pulse at cycle %0d note=%0d, required none", cyc, note);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || int'(note) != e.note || note_valid != e.valid) begin
            errors++;
            $display("FAIL pulse: cycle %0d note=%0d valid=%0b, required cycle %0d note=%0d valid=%0b",
                     cyc, note, note_valid, e.cyc, e.note, e.valid);
          end
        end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missed_pulse: none by cycle %0d, required at cycle %0d note=%0d",
                 cyc, e.cyc, e.note);
      end
    end
  endtask

  initial begin
    int k, left, d;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_note", int'(note), 0);
    chk("reset_valid", int'(note_valid), 0);
    chk("reset_change", int'(note_change), 0);

    // idle: silent line produces nothing
    repeat (3500) @(negedge clk);
    chk("idle_note", int'(note), 0);

    // lock on mi
    tog(20); tog(1515); tog(1515); tog(1515);
    // do, then switch to la
    tog(1908); tog(1908); tog(1136); tog(1136);
    // tolerance edges around sol
    tog(1275 + TOL); tog(1275 + TOL); tog(1275 + TOL);
    tog(1275 + TOL + 1); tog(1275 + TOL + 1); tog(1275 + TOL + 1);
    tog(1275 - TOL); tog(1275 - TOL); tog(1275 - TOL - 1);
    // si, an edge landing exactly on TIMEOUT, then a real timeout
    tog(1012); tog(1012); tog(TMO); tog(1012); tog(1012);
    tog(TMO + 200);
    // re locked, then enable dropped
    tog(1701); tog(1701);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    if (m_note != 0) expect_change(cyc + 1, 0);
    m_silence();
    repeat (20) @(negedge clk);
    chk("disabled_note", int'(note), 0);
    chk("disabled_valid", int'(note_valid), 0);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    // re locked again, then an asynchronous reset
    tog(20); tog(1701); tog(1701);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_note", int'(note), 0);
    chk("async_rst_valid", int'(note_valid), 0);
    chk("async_rst_change", int'(note_change), 0);
    tone_in = 1'b0;
    m_silence();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // random bursts of in-window and near-miss half-periods
    tog(20);
    left = 0; k = 1;
    for (int i = 0; i < 18; i++) begin
      if (left == 0) begin
        k    = int'($urandom_range(1, 7));
        left = int'($urandom_range(1, 3));
      end
      left--;
      if ($urandom_range(0, 4) != 0)
        d = nomt[k] + int'($urandom_range(0, 2 * TOL)) - TOL;
      else if ($urandom_range(0, 1) != 0)
        d = nomt[k] + TOL + 1 + int'($urandom_range(0, 30));
      else
        d = nomt[k] - TOL - 1 - int'($urandom_range(0, 30));
      tog(d);
    end

    // let any lock lapse, then everything predicted must have appeared
    m_timeout_chk(cyc + TMO + 10);
    repeat (TMO + 20) @(negedge clk);
    chk("pending_events", q.size(), 0);
    chk("final_note", int'(note), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
